// File: rtl/fft_conv_pkg.sv
// Shared geometry, FSM encoding and tile packing helper for the FFT tile loader and PE_fft.
// FFT_TILE_PAD_EN selects a virtual zero border of (KERNEL_SIZE-1)/2 pixels.
package fft_conv_pkg;

    localparam int DEF_KERNEL_SIZE      = 3;
    localparam int DEF_INPUT_TILE_SIZE  = 4;
    localparam int DEF_INPUT_DATA_WIDTH = 8;
    localparam int DEF_CHANNELS         = 3;
    localparam int DEF_IMG_W            = 8;
    localparam int DEF_IMG_H            = 8;

    localparam int STRIDE = DEF_INPUT_TILE_SIZE - DEF_KERNEL_SIZE + 1;
    localparam int PIX_W  = DEF_CHANNELS * DEF_INPUT_DATA_WIDTH;
    localparam int TILE_W = DEF_INPUT_TILE_SIZE * DEF_INPUT_TILE_SIZE * PIX_W;
`ifdef FFT_TILE_PAD_EN
    localparam int PAD    = (DEF_KERNEL_SIZE - 1) / 2;
`else
    localparam int PAD    = 0;
`endif

    // Width of the internal row/column counters and anchors.
    localparam int AW = 16;

    typedef enum logic [1:0] {
        LD_FILL = 2'd0,
        LD_EMIT = 2'd1,
        LD_DONE = 2'd2
    } ld_state_e;

    // LSB position of element (r,c) of channel ch inside a packed inpData tile.
    function automatic int tile_bit_index(input int ch, input int r, input int c);
        return (ch * DEF_INPUT_TILE_SIZE * DEF_INPUT_TILE_SIZE
                + (DEF_INPUT_TILE_SIZE * DEF_INPUT_TILE_SIZE - 1
                   - (r * DEF_INPUT_TILE_SIZE + c))) * DEF_INPUT_DATA_WIDTH;
    endfunction

endpackage

// File: rtl/fft_tile_line_buffer.sv
// Circular T-row line buffer: one pixel write port and a combinational T x T tap window.
// Taps outside the real image (virtual border) read as zero; a same-cycle write is forwarded.
module fft_tile_line_buffer
    import fft_conv_pkg::*;
#(
    parameter int T        = 4,
    parameter int IMG_W    = 8,
    parameter int IMG_H    = 8,
    parameter int PIX_BITS = 24,
    parameter int BORDER   = 0,
    localparam int RB      = (T > 1) ? $clog2(T) : 1,
    localparam int CB      = (IMG_W > 1) ? $clog2(IMG_W) : 1
) (
    input  logic                       clk,
    input  logic                       we,
    input  logic [RB-1:0]              wr_row,
    input  logic [CB-1:0]              wr_col,
    input  logic [PIX_BITS-1:0]        wr_data,
    input  logic [AW-1:0]              base_row,
    input  logic [AW-1:0]              col_anchor,
    output logic [T*T*PIX_BITS-1:0]    taps
);

    logic [PIX_BITS-1:0] mem [T][IMG_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_row][wr_col] <= wr_data;
        end
    end

    // base_row/col_anchor are in padded coordinates; image row y lives in physical row y mod T.
    always_comb begin
        int            iy;
        int            ix;
        logic [RB-1:0] pr;
        logic [CB-1:0] pc;
        taps = '0;
        iy   = 0;
        ix   = 0;
        pr   = '0;
        pc   = '0;
        for (int r = 0; r < T; r++) begin
            for (int c = 0; c < T; c++) begin
                iy = int'(base_row) + r - BORDER;
                ix = int'(col_anchor) + c - BORDER;
                if (iy >= 0 && iy < IMG_H && ix >= 0 && ix < IMG_W) begin
                    pr = RB'(iy % T);
                    pc = CB'(ix);
                    if (we && pr == wr_row && pc == wr_col) begin
                        taps[(r*T + c)*PIX_BITS +: PIX_BITS] = wr_data;
                    end else begin
                        taps[(r*T + c)*PIX_BITS +: PIX_BITS] = mem[pr][pc];
                    end
                end
            end
        end
    end

endmodule

// File: rtl/fft_tile_loader.sv
// Raster pixel stream -> overlapping T x T x C tiles in PE_fft inpData packing, valid/ready on both sides.
// Optional virtual zero border: define FFT_TILE_PAD_EN.
module fft_tile_loader
    import fft_conv_pkg::*;
#(
    parameter int KERNEL_SIZE      = DEF_KERNEL_SIZE,
    parameter int INPUT_TILE_SIZE  = DEF_INPUT_TILE_SIZE,
    parameter int INPUT_DATA_WIDTH = DEF_INPUT_DATA_WIDTH,
    parameter int CHANNELS         = DEF_CHANNELS,
    parameter int IMG_W            = DEF_IMG_W,
    parameter int IMG_H            = DEF_IMG_H
) (
    input  logic                                                                    clk,
    input  logic                                                                    reset,
    input  logic                                                                    pix_valid,
    output logic                                                                    pix_ready,
    input  logic [CHANNELS*INPUT_DATA_WIDTH-1:0]                                    pix_data,
    output logic                                                                    tile_valid,
    input  logic                                                                    tile_ready,
    output logic [INPUT_TILE_SIZE*INPUT_TILE_SIZE*INPUT_DATA_WIDTH*CHANNELS-1:0]    tile_data,
    output logic [7:0]                                                              tile_row,
    output logic [7:0]                                                              tile_col,
    output logic                                                                    frame_done
);

    // Handshakes: a pixel moves on a cycle where pix_valid && pix_ready, a tile on tile_valid && tile_ready;
    // the producer holds its payload stable until that cycle, and valid never depends on ready.

    localparam int T       = INPUT_TILE_SIZE;
    localparam int W       = INPUT_DATA_WIDTH;
    localparam int C       = CHANNELS;
    localparam int STEP    = T - KERNEL_SIZE + 1;
`ifdef FFT_TILE_PAD_EN
    localparam int BORDER  = (KERNEL_SIZE - 1) / 2;
`else
    localparam int BORDER  = 0;
`endif
    localparam int PXW     = C * W;
    localparam int TLW     = T * T * PXW;
    localparam int FRAME_W = IMG_W + 2 * BORDER;
    localparam int FRAME_H = IMG_H + 2 * BORDER;
    localparam int RB      = (T > 1) ? $clog2(T) : 1;
    localparam int CB      = (IMG_W > 1) ? $clog2(IMG_W) : 1;

    localparam logic [AW-1:0] LAST_COL = AW'(FRAME_W - T);
    localparam logic [AW-1:0] LAST_ROW = AW'(FRAME_H - T);
    localparam logic [AW-1:0] STEP_A   = AW'(STEP);
    localparam logic [AW-1:0] X_MAX    = AW'(IMG_W - 1);

    ld_state_e        state;
    ld_state_e        state_nxt;

    logic [AW-1:0]    row_anchor;
    logic [AW-1:0]    col_anchor;
    logic [AW-1:0]    wr_y;
    logic [AW-1:0]    wr_x;
    logic [AW-1:0]    rd_col;
    logic [RB-1:0]    wr_row;
    int               fill_end;

    logic             fill_empty;
    logic             pix_fire;
    logic             last_pix;
    logic             tile_fire;
    logic             at_last_col;
    logic             at_last_row;
    logic             load;

    logic [TLW-1:0]   taps;
    logic [TLW-1:0]   tile_next;
    logic [TLW-1:0]   tile_q;
    logic [7:0]       row_q;
    logic [7:0]       col_q;

    // Last image row the current FILL must reach before the row_anchor tiles can be assembled.
    always_comb begin
        fill_end = int'(row_anchor) + T - 1 - BORDER;
        if (fill_end > IMG_H - 1) begin
            fill_end = IMG_H - 1;
        end
    end

    assign fill_empty  = int'(wr_y) > fill_end;
    assign pix_ready   = (state == LD_FILL) && !fill_empty && !reset;
    assign pix_fire    = pix_valid && pix_ready;
    assign last_pix    = pix_fire && (wr_x == X_MAX) && (int'(wr_y) == fill_end);
    assign tile_valid  = (state == LD_EMIT);
    assign tile_fire   = tile_valid && tile_ready;
    assign frame_done  = (state == LD_DONE);
    assign at_last_col = (col_anchor == LAST_COL);
    assign at_last_row = (row_anchor == LAST_ROW);
    assign rd_col      = (state == LD_EMIT) ? col_anchor + STEP_A : '0;
    assign wr_row      = RB'(int'(wr_y) % T);

    assign tile_data   = tile_q;
    assign tile_row    = row_q;
    assign tile_col    = col_q;

    fft_tile_line_buffer #(
        .T        (T),
        .IMG_W    (IMG_W),
        .IMG_H    (IMG_H),
        .PIX_BITS (PXW),
        .BORDER   (BORDER)
    ) u_line_buffer (
        .clk        (clk),
        .we         (pix_fire),
        .wr_row     (wr_row),
        .wr_col     (wr_x[CB-1:0]),
        .wr_data    (pix_data),
        .base_row   (row_anchor),
        .col_anchor (rd_col),
        .taps       (taps)
    );

    // Taps are row-major with all channels per pixel; inpData wants channel planes, (0,0) at the top.
    always_comb begin
        tile_next = '0;
        for (int ch = 0; ch < C; ch++) begin
            for (int r = 0; r < T; r++) begin
                for (int c = 0; c < T; c++) begin
                    tile_next[(ch*T*T + (T*T - 1 - (r*T + c)))*W +: W] =
                        taps[(r*T + c)*PXW + ch*W +: W];
                end
            end
        end
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        case (state)
            LD_FILL: begin
                if (last_pix || fill_empty) begin
                    load      = 1'b1;
                    state_nxt = LD_EMIT;
                end
            end
            LD_EMIT: begin
                if (tile_fire) begin
                    if (!at_last_col) begin
                        load = 1'b1;
                    end else if (!at_last_row) begin
                        state_nxt = LD_FILL;
                    end else begin
                        state_nxt = LD_DONE;
                    end
                end
            end
            LD_DONE: begin
                state_nxt = LD_FILL;
            end
            default: begin
                state_nxt = LD_FILL;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= LD_FILL;
            row_anchor <= '0;
            col_anchor <= '0;
            wr_y       <= '0;
            wr_x       <= '0;
            tile_q     <= '0;
            row_q      <= '0;
            col_q      <= '0;
        end else begin
            state <= state_nxt;

            if (pix_fire) begin
                if (wr_x == X_MAX) begin
                    wr_x <= '0;
                    wr_y <= wr_y + AW'(1);
                end else begin
                    wr_x <= wr_x + AW'(1);
                end
            end

            if (load) begin
                tile_q <= tile_next;
                row_q  <= row_anchor[7:0];
                col_q  <= rd_col[7:0];
            end

            if (tile_fire) begin
                if (!at_last_col) begin
                    col_anchor <= col_anchor + STEP_A;
                end else begin
                    col_anchor <= '0;
                    row_anchor <= at_last_row ? '0 : row_anchor + STEP_A;
                end
            end

            // Start the next frame's raster from pixel (0,0).
            if (state == LD_DONE) begin
                wr_y <= '0;
                wr_x <= '0;
            end
        end
    end

endmodule

// File: tb/tb_fft_tile_loader.sv
// Self-checking bench for fft_tile_loader: random/pattern frames vs. a tile-enumerating reference model.
// Honours FFT_TILE_PAD_EN in the model when the design is built with it.
module tb_fft_tile_loader;

    localparam int K     = 3;
    localparam int T     = 4;
    localparam int W     = 8;
    localparam int C     = 3;
    localparam int IMG_W = 8;
    localparam int IMG_H = 8;
    localparam int S     = T - K + 1;
`ifdef FFT_TILE_PAD_EN
    localparam int P     = (K - 1) / 2;
`else
    localparam int P     = 0;
`endif
    localparam int PW       = IMG_W + 2 * P;
    localparam int PH       = IMG_H + 2 * P;
    localparam int NT       = ((PH - T) / S + 1) * ((PW - T) / S + 1);
    localparam int PXW      = C * W;
    localparam int TLW      = T * T * PXW;
    localparam int FE0      = (T - 1 - P < IMG_H - 1) ? T - 1 - P : IMG_H - 1;
    localparam int FIRST_PX = (FE0 + 1) * IMG_W;

    // clock / reset
    logic           clk;
    logic           reset;
    logic           pix_valid;
    logic           pix_ready;
    logic [PXW-1:0] pix_data;
    logic           tile_valid;
    logic           tile_ready;
    logic [TLW-1:0] tile_data;
    logic [7:0]     tile_row;
    logic [7:0]     tile_col;
    logic           frame_done;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    fft_tile_loader dut (
        .clk        (clk),
        .reset      (reset),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .pix_data   (pix_data),
        .tile_valid (tile_valid),
        .tile_ready (tile_ready),
        .tile_data  (tile_data),
        .tile_row   (tile_row),
        .tile_col   (tile_col),
        .frame_done (frame_done)
    );

    // scoreboard
    logic [TLW-1:0] exp_q[$];
    logic [7:0]     exp_row_q[$];
    logic [7:0]     exp_col_q[$];
    int             checks;
    int             failures;

    logic [PXW-1:0] img [IMG_H][IMG_W];
    logic           abort;
    logic           ready_rand;
    logic           pattern_mode;
    int             hs_frame;
    logic           fd_pend;
    logic           lat_pend;
    int             px_frame;

    task automatic chk(input string tag, input logic [TLW-1:0] got, input logic [TLW-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic make_image(input logic pattern);
        logic [7:0] v;
        for (int y = 0; y < IMG_H; y++) begin
            for (int x = 0; x < IMG_W; x++) begin
                v = 8'(8 * y + x);
                if (pattern) img[y][x] = {8'(-v), 8'd1, v};
                else         img[y][x] = PXW'($urandom);
            end
        end
    endtask

    // Reference: every tile of the (optionally padded) frame in raster order of anchors.
    task automatic push_frame();
        logic [TLW-1:0] t;
        logic [PXW-1:0] px;
        int iy;
        int ix;
        for (int ra = 0; ra <= PH - T; ra += S) begin
            for (int ca = 0; ca <= PW - T; ca += S) begin
                t = '0;
                for (int ch = 0; ch < C; ch++) begin
                    for (int r = 0; r < T; r++) begin
                        for (int c = 0; c < T; c++) begin
                            iy = ra + r - P;
                            ix = ca + c - P;
                            px = '0;
                            if (iy >= 0 && iy < IMG_H && ix >= 0 && ix < IMG_W) px = img[iy][ix];
                            t[(ch*T*T + (T*T - 1 - (r*T + c)))*W +: W] = px[ch*W +: W];
                        end
                    end
                end
                exp_q.push_back(t);
                exp_row_q.push_back(8'(ra));
                exp_col_q.push_back(8'(ca));
            end
        end
    endtask

    // driver tasks
    task automatic send_pixel(input logic [PXW-1:0] d, input int gap_pct);
        int   tmo;
        logic got;
        while (!abort && $urandom_range(0, 99) < gap_pct) begin
            pix_valid = 1'b0;
            @(posedge clk);
            #1;
        end
        pix_data  = d;
        pix_valid = 1'b1;
        got = 1'b0;
        tmo = 0;
        while (!got && !abort) begin
            @(negedge clk);
            got = pix_ready;
            @(posedge clk);
            #1;
            tmo++;
            if (!got && tmo > 3000) begin
                chk("pix_accept_timeout", TLW'(0), TLW'(1));
                abort = 1'b1;
            end
        end
        pix_valid = 1'b0;
    endtask

    task automatic send_frame(input int gap_pct);
        for (int y = 0; y < IMG_H; y++) begin
            for (int x = 0; x < IMG_W; x++) begin
                if (!abort) send_pixel(img[y][x], gap_pct);
            end
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 5000 && exp_q.size() > 0; i++) @(posedge clk);
        chk("drain_remaining", TLW'(exp_q.size()), TLW'(0));
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        tile_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            tile_ready = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // monitor: sampled on the falling edge, away from the active edge
    initial begin
        hs_frame = 0;
        fd_pend  = 1'b0;
        lat_pend = 1'b0;
        px_frame = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                hs_frame = 0;
                fd_pend  = 1'b0;
                lat_pend = 1'b0;
                px_frame = 0;
            end else begin
                chk("frame_done", TLW'(frame_done), TLW'(fd_pend));
                fd_pend = 1'b0;
                if (lat_pend) chk("first_tile_latency", TLW'(tile_valid), TLW'(1));
                lat_pend = 1'b0;
                if (pix_valid && pix_ready) begin
                    px_frame++;
                    if (px_frame == FIRST_PX) lat_pend = 1'b1;
                    if (px_frame == IMG_W * IMG_H) px_frame = 0;
                end
                if (tile_valid) begin
                    chk("pix_ready_in_emit", TLW'(pix_ready), TLW'(0));
                    if (exp_q.size() == 0) begin
                        chk("unexpected_tile", TLW'(1), TLW'(0));
                    end else begin
                        chk("tile_data", tile_data, exp_q[0]);
                        chk("tile_row", TLW'(tile_row), TLW'(exp_row_q[0]));
                        chk("tile_col", TLW'(tile_col), TLW'(exp_col_q[0]));
                        if (tile_ready) begin
`ifndef FFT_TILE_PAD_EN
                            if (pattern_mode)
                                chk("ch0_origin", TLW'(tile_data[(T*T-1)*W +: W]),
                                    TLW'(8'(8 * tile_row + tile_col)));
`endif
                            void'(exp_q.pop_front());
                            void'(exp_row_q.pop_front());
                            void'(exp_col_q.pop_front());
                            hs_frame++;
                            if (hs_frame == NT) begin
                                fd_pend  = 1'b1;
                                hs_frame = 0;
                            end
                        end
                    end
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog t=%0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks       = 0;
        failures     = 0;
        reset        = 1'b1;
        pix_valid    = 1'b0;
        pix_data     = '0;
        abort        = 1'b0;
        ready_rand   = 1'b0;
        pattern_mode = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_pix_ready", TLW'(pix_ready), TLW'(0));
        chk("reset_tile_valid", TLW'(tile_valid), TLW'(0));
        chk("reset_frame_done", TLW'(frame_done), TLW'(0));
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("post_reset_pix_ready", TLW'(pix_ready), TLW'(1));
        chk("post_reset_tile_valid", TLW'(tile_valid), TLW'(0));
        chk("post_reset_tile_data", tile_data, TLW'(0));
        chk("post_reset_tile_row", TLW'(tile_row), TLW'(0));
        chk("post_reset_tile_col", TLW'(tile_col), TLW'(0));
        @(posedge clk);
        #1;

        // pattern frame, consumer always ready
        make_image(1'b1);
        pattern_mode = 1'b1;
        push_frame();
        send_frame(0);
        drain();

        // same frame, consumer stalls randomly
        ready_rand = 1'b1;
        push_frame();
        send_frame(0);
        drain();
        ready_rand = 1'b0;

        // same frame, gapped pixel stream
        push_frame();
        send_frame(50);
        drain();

        // reset after the fourth tile, then a fresh random frame
        push_frame();
        fork
            send_frame(0);
            begin
                for (int i = 0; i < 3000 && hs_frame < 4; i++) @(posedge clk);
                chk("reset_trigger_reached", TLW'(hs_frame >= 4), TLW'(1));
                abort = 1'b1;
            end
        join
        reset = 1'b1;
        exp_q.delete();
        exp_row_q.delete();
        exp_col_q.delete();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        abort = 1'b0;
        pattern_mode = 1'b0;
        make_image(1'b0);
        push_frame();
        send_frame(0);
        drain();

        // two back-to-back frames of one random image with random stalls
        ready_rand = 1'b1;
        make_image(1'b0);
        push_frame();
        push_frame();
        send_frame(0);
        send_frame(0);
        drain();
        ready_rand = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
